// File: rtl/reg_bus_pkg.sv
// rtl/reg_bus_pkg.sv - shared types and constants for the register bus arbiter
package reg_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    CAP  = 2'd3
  } state_e;

  localparam int REG_ADDR_W = 6;
  localparam int REG_DATA_W = 8;
  localparam int PORT_HOST  = 0;
  localparam int PORT_SEQ   = 1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with done mask and pointer advance
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic [1:0] done_mask,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_valid
);
  import reg_bus_pkg::*;

  logic       ptr;
  logic [1:0] eligible;

  // A port completing this cycle must not be re-granted on its stale request.
  always_comb begin
    eligible = req & ~done_mask;
    grant    = eligible;
    if (eligible == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  assign grant_valid = |eligible;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 1'(PORT_HOST);
    end else if (advance && grant_valid) begin
      ptr <= grant[PORT_HOST] ? 1'(PORT_SEQ) : 1'(PORT_HOST);
    end
  end

endmodule

// File: rtl/reg_bus_arbiter.sv
// rtl/reg_bus_arbiter.sv - two-port register bus arbiter sequencing narrow and wide beats
module reg_bus_arbiter
  import reg_bus_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_i,
  input  logic [1:0]          we_i,
  input  logic [1:0]          wide_i,
  input  logic [ADDR_W-1:0]   addr0_i,
  input  logic [ADDR_W-1:0]   addr1_i,
  input  logic [2*DATA_W-1:0] wdata0_i,
  input  logic [2*DATA_W-1:0] wdata1_i,
  output logic [1:0]          done_o,
  output logic [2*DATA_W-1:0] rdata_o,
  output logic                bus_read,
  output logic                bus_write,
  output logic [ADDR_W-1:0]   bus_addr,
  output logic [DATA_W-1:0]   bus_wdata,
  input  logic [DATA_W-1:0]   bus_rdata
);

  state_e                state, state_nx;
  logic [1:0]            gnt;
  logic                  gnt_valid;
  logic                  win_port, win_we, win_wide;
  logic [ADDR_W-1:0]     win_addr;
  logic [2*DATA_W-1:0]   win_wdata;

  logic                  cmd_port, cmd_we, cmd_wide;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [2*DATA_W-1:0]   cmd_wdata;
  logic [DATA_W-1:0]     res_lo;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req_i),
    .done_mask   (done_o),
    .advance     (state == IDLE),
    .grant       (gnt),
    .grant_valid (gnt_valid)
  );

  always_comb begin
    win_port  = (gnt == 2'b10);
    win_we    = we_i[win_port];
    win_wide  = wide_i[win_port];
    win_addr  = win_port ? addr1_i : addr0_i;
    win_wdata = win_port ? wdata1_i : wdata0_i;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (gnt_valid) state_nx = LO;
      LO:   state_nx = cmd_wide ? HI : CAP;
      HI:   state_nx = CAP;
      CAP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs are registered off the current state so each beat lands in
  // the cycle its state is named for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cmd_port  <= 1'b0;
      cmd_we    <= 1'b0;
      cmd_wide  <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      res_lo    <= '0;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      done_o    <= 2'b00;
      rdata_o   <= '0;
    end else begin
      state     <= state_nx;
      bus_read  <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      done_o    <= 2'b00;
      rdata_o   <= '0;
      unique case (state)
        IDLE: begin
          if (gnt_valid) begin
            cmd_port  <= win_port;
            cmd_we    <= win_we;
            cmd_wide  <= win_wide;
            cmd_addr  <= win_addr;
            cmd_wdata <= win_wdata;
            bus_addr  <= win_addr;
            bus_write <= win_we;
            bus_read  <= !win_we;
            if (win_we) bus_wdata <= win_wdata[DATA_W-1:0];
          end
        end
        LO: begin
          if (cmd_wide) begin
            bus_addr  <= cmd_addr + ADDR_W'(1);
            bus_write <= cmd_we;
            bus_read  <= !cmd_we;
            if (cmd_we) bus_wdata <= cmd_wdata[2*DATA_W-1:DATA_W];
          end
        end
        HI: begin
          if (!cmd_we) res_lo <= bus_rdata;
        end
        CAP: begin
          done_o[cmd_port] <= 1'b1;
          if (!cmd_we) begin
            rdata_o <= cmd_wide ? {bus_rdata, res_lo} : {{DATA_W{1'b0}}, bus_rdata};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb/tb_reg_bus_arbiter.sv - directed self-checking bench for reg_bus_arbiter
module tb_reg_bus_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_i, we_i, wide_i;
  logic [5:0]  addr0_i, addr1_i;
  logic [15:0] wdata0_i, wdata1_i;
  logic [1:0]  done_o;
  logic [15:0] rdata_o;
  logic        bus_read, bus_write;
  logic [5:0]  bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;

  int total = 0;
  int bad   = 0;

  logic [7:0]  mem [0:63];
  logic [15:0] beat    [0:31];
  logic [1:0]  done_s  [0:31];
  logic [15:0] rdata_s [0:31];

  reg_bus_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .we_i      (we_i),
    .wide_i    (wide_i),
    .addr0_i   (addr0_i),
    .addr1_i   (addr1_i),
    .wdata0_i  (wdata0_i),
    .wdata1_i  (wdata1_i),
    .done_o    (done_o),
    .rdata_o   (rdata_o),
    .bus_read  (bus_read),
    .bus_write (bus_write),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file model with registered read data
  always @(posedge clk) begin
    if (bus_write) mem[bus_addr] <= bus_wdata;
    if (bus_read) bus_rdata <= mem[bus_addr];
  end

  task automatic capture(input int n, input bit drop);
    for (int c = 1; c <= n; c++) begin
      @(posedge clk); #1;
      beat[c]    = {bus_write, bus_read, bus_addr, bus_wdata};
      done_s[c]  = done_o;
      rdata_s[c] = rdata_o;
      if (drop && done_o != 2'b00) req_i = req_i & ~done_o;
    end
  endtask

  task automatic issue(input int port, input bit we, input bit wide,
                       input logic [5:0] addr, input logic [15:0] wdata);
    @(posedge clk); #1;
    we_i[port]   = we;
    wide_i[port] = wide;
    if (port == 0) begin addr0_i = addr; wdata0_i = wdata; end
    else           begin addr1_i = addr; wdata1_i = wdata; end
    req_i[port]  = 1'b1;
  endtask

  task automatic test_reset;
    total++; if (bus_read !== 1'b0) begin bad++; $display("FAIL reset_bus_read got=%b exp=0", bus_read); end
    total++; if (bus_write !== 1'b0) begin bad++; $display("FAIL reset_bus_write got=%b exp=0", bus_write); end
    total++; if (bus_addr !== 6'h00) begin bad++; $display("FAIL reset_bus_addr got=%h exp=00", bus_addr); end
    total++; if (done_o !== 2'b00) begin bad++; $display("FAIL reset_done got=%b exp=00", done_o); end
    total++; if (rdata_o !== 16'h0000) begin bad++; $display("FAIL reset_rdata got=%h exp=0000", rdata_o); end
  endtask

  task automatic test_narrow_write;
    issue(0, 1'b1, 1'b0, 6'h0A, 16'h0037);
    capture(3, 1'b1);
    total++; if (beat[1] !== {1'b1, 1'b0, 6'h0A, 8'h37}) begin bad++; $display("FAIL narrow_wr_lo got=%h exp=%h", beat[1], {1'b1, 1'b0, 6'h0A, 8'h37}); end
    total++; if (beat[2] !== 16'h0000) begin bad++; $display("FAIL narrow_wr_no_hi got=%h exp=0000", beat[2]); end
    total++; if (done_s[2] !== 2'b00) begin bad++; $display("FAIL narrow_wr_early_done got=%b exp=00", done_s[2]); end
    total++; if (done_s[3] !== 2'b01) begin bad++; $display("FAIL narrow_wr_done got=%b exp=01", done_s[3]); end
  endtask

  task automatic test_wide_write;
    issue(1, 1'b1, 1'b1, 6'h03, 16'hBEEF);
    capture(4, 1'b1);
    total++; if (beat[1] !== {1'b1, 1'b0, 6'h03, 8'hEF}) begin bad++; $display("FAIL wide_wr_lo got=%h exp=%h", beat[1], {1'b1, 1'b0, 6'h03, 8'hEF}); end
    total++; if (beat[2] !== {1'b1, 1'b0, 6'h04, 8'hBE}) begin bad++; $display("FAIL wide_wr_hi got=%h exp=%h", beat[2], {1'b1, 1'b0, 6'h04, 8'hBE}); end
    total++; if (beat[3] !== 16'h0000 || done_s[3] !== 2'b00) begin bad++; $display("FAIL wide_wr_cap got=%h/%b exp=0000/00", beat[3], done_s[3]); end
    total++; if (done_s[4] !== 2'b10) begin bad++; $display("FAIL wide_wr_done got=%b exp=10", done_s[4]); end
  endtask

  task automatic test_reads;
    issue(1, 1'b1, 1'b1, 6'h08, 16'h1234);
    capture(4, 1'b1);
    issue(0, 1'b1, 1'b0, 6'h0D, 16'h00A5);
    capture(3, 1'b1);
    issue(0, 1'b0, 1'b1, 6'h08, 16'h0000);
    capture(4, 1'b1);
    total++; if (beat[1] !== {1'b0, 1'b1, 6'h08, 8'h00}) begin bad++; $display("FAIL wide_rd_lo got=%h exp=%h", beat[1], {1'b0, 1'b1, 6'h08, 8'h00}); end
    total++; if (beat[2] !== {1'b0, 1'b1, 6'h09, 8'h00}) begin bad++; $display("FAIL wide_rd_hi got=%h exp=%h", beat[2], {1'b0, 1'b1, 6'h09, 8'h00}); end
    total++; if (beat[3] !== 16'h0000) begin bad++; $display("FAIL wide_rd_cap_strobe got=%h exp=0000", beat[3]); end
    total++; if (done_s[4] !== 2'b01 || rdata_s[4] !== 16'h1234) begin bad++; $display("FAIL wide_rd_result got=%b/%h exp=01/1234", done_s[4], rdata_s[4]); end
    issue(1, 1'b0, 1'b0, 6'h0D, 16'h0000);
    capture(3, 1'b1);
    total++; if (beat[1] !== {1'b0, 1'b1, 6'h0D, 8'h00}) begin bad++; $display("FAIL narrow_rd_lo got=%h exp=%h", beat[1], {1'b0, 1'b1, 6'h0D, 8'h00}); end
    total++; if (done_s[3] !== 2'b10 || rdata_s[3] !== 16'h00A5) begin bad++; $display("FAIL narrow_rd_result got=%b/%h exp=10/00a5", done_s[3], rdata_s[3]); end
  endtask

  task automatic test_wrap;
    issue(0, 1'b1, 1'b1, 6'h3F, 16'h5A6B);
    capture(4, 1'b1);
    total++; if (beat[1] !== {1'b1, 1'b0, 6'h3F, 8'h6B}) begin bad++; $display("FAIL wrap_lo got=%h exp=%h", beat[1], {1'b1, 1'b0, 6'h3F, 8'h6B}); end
    total++; if (beat[2] !== {1'b1, 1'b0, 6'h00, 8'h5A}) begin bad++; $display("FAIL wrap_hi got=%h exp=%h", beat[2], {1'b1, 1'b0, 6'h00, 8'h5A}); end
    total++; if (done_s[4] !== 2'b01) begin bad++; $display("FAIL wrap_done got=%b exp=01", done_s[4]); end
  endtask

  task automatic test_reset_mid;
    issue(0, 1'b1, 1'b1, 6'h30, 16'hCAFE);
    capture(2, 1'b1);
    total++; if (beat[2] !== {1'b1, 1'b0, 6'h31, 8'hCA}) begin bad++; $display("FAIL rstmid_hi_beat got=%h exp=%h", beat[2], {1'b1, 1'b0, 6'h31, 8'hCA}); end
    rst_n = 1'b0;
    #1;
    total++; if ({bus_write, bus_read, bus_addr, bus_wdata} !== 16'h0000) begin bad++; $display("FAIL rstmid_bus_zero got=%h exp=0000", {bus_write, bus_read, bus_addr, bus_wdata}); end
    total++; if (done_o !== 2'b00 || rdata_o !== 16'h0000) begin bad++; $display("FAIL rstmid_out_zero got=%b/%h exp=00/0000", done_o, rdata_o); end
    req_i = 2'b00;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    capture(4, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      total++;
      if (beat[c] !== 16'h0000 || done_s[c] !== 2'b00) begin
        bad++; $display("FAIL rstmid_quiet c=%0d got=%h/%b exp=0000/00", c, beat[c], done_s[c]);
      end
    end
  endtask

  task automatic test_contention;
    logic [15:0] exp_beat;
    logic [1:0]  exp_done;
    logic [5:0]  base;
    logic [15:0] wd;
    int p, ph;
    @(posedge clk); #1;
    we_i = 2'b11; wide_i = 2'b11;
    addr0_i = 6'h10; wdata0_i = 16'h1211;
    addr1_i = 6'h20; wdata1_i = 16'h2221;
    req_i = 2'b11;
    capture(16, 1'b0);
    for (int c = 1; c <= 16; c++) begin
      p  = ((c - 1) / 4) % 2;
      ph = (c - 1) % 4;
      base = (p == 1) ? 6'h20 : 6'h10;
      wd   = (p == 1) ? 16'h2221 : 16'h1211;
      exp_beat = 16'h0000;
      exp_done = 2'b00;
      if (ph == 0) exp_beat = {1'b1, 1'b0, base, wd[7:0]};
      if (ph == 1) exp_beat = {1'b1, 1'b0, base + 6'd1, wd[15:8]};
      if (ph == 3) exp_done = (p == 1) ? 2'b10 : 2'b01;
      total++;
      if (beat[c] !== exp_beat || done_s[c] !== exp_done) begin
        bad++; $display("FAIL contention c=%0d got=%h/%b exp=%h/%b", c, beat[c], done_s[c], exp_beat, exp_done);
      end
    end
    req_i = 2'b00;
    capture(5, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    req_i = 2'b00; we_i = 2'b00; wide_i = 2'b00;
    addr0_i = '0; addr1_i = '0; wdata0_i = '0; wdata1_i = '0;
    bus_rdata = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    test_reset;
    rst_n = 1'b1;
    test_narrow_write;
    test_wide_write;
    test_reads;
    test_wrap;
    test_reset_mid;
    test_contention;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
# reg_bus_arbiter

Two-port arbiter and sequencer for the byte-wide peripheral register bus. It sits between two register masters (the host SPI decoder on port 0, an on-chip config sequencer on port 1) and the PWM register file. It grants the bus round-robin and turns each request into one or two byte beats. A 16-bit ("wide") request runs as two back-to-back, non-interruptible beats at `addr` and `addr+1`, so the period, compare1 and compare2 halves never tear.

## Interface
Parameters:
- `ADDR_W`, default 6: register address width.
- `DATA_W`, default 8: bus byte width; the wide payload is `2*DATA_W`.

Ports:
- `clk` in 1: peripheral clock; single clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_i[1:0]` in 2: per-port request. Must be held with its command fields stable until that port's `done_o` pulse.
- `we_i[1:0]` in 2: per-port write (1) or read (0).
- `wide_i[1:0]` in 2: per-port 16-bit access (1) or single byte (0).
- `addr0_i`, `addr1_i` in ADDR_W each: start address.
- `wdata0_i`, `wdata1_i` in 16 each: write payload. The low byte goes to `addr`, the high byte to `addr+1`. Narrow writes use `[7:0]`.
- `done_o[1:0]` out 2: one-cycle completion pulse per port.
- `rdata_o` out 16: read result, valid only while `done_o` is high. Narrow reads are zero-extended.
- `bus_read` out 1: read strobe to the register file.
- `bus_write` out 1: write strobe to the register file.
- `bus_addr` out ADDR_W: register address.
- `bus_wdata` out DATA_W: write byte.
- `bus_rdata` in DATA_W: registered read data from the register file. It is valid the cycle after `bus_read` and holds until the next read.

## Operation
- FSM states: IDLE, LO, HI, CAP.
- IDLE:
  - Masks any port whose `done_o` is high this cycle.
  - Picks among the remaining active `req_i` bits.
  - If exactly one port requests, that port wins. If both request, the port named by the round-robin pointer wins.
  - Latches the winner's command, moves to LO, and sets the pointer to the other port.
  - The pointer resets to port 0.
- LO: drives `bus_addr=addr` and asserts `bus_read` or `bus_write`; on write, `bus_wdata=wdata[7:0]`. Next state is HI if wide, else CAP.
- HI:
  - Drives `bus_addr=addr+1`, taken modulo 2^ADDR_W (0x3F wraps to 0x00).
  - On write, `bus_wdata=wdata[15:8]`.
  - On read, asserts `bus_read` and captures `bus_rdata` into the low result byte.
  - Next state is CAP.
- CAP:
  - No bus strobe.
  - On read, captures `bus_rdata`: into the high byte if wide, into the low byte if narrow.
  - Next state is IDLE, with the granted port's `done_o` and `rdata_o` registered for the following cycle.
- Strobes are never asserted outside LO and HI. `bus_read` and `bus_write` are never asserted together.
- Requests arriving during a transaction wait. There is no preemption and no dropped request.
- `we` and `wide` are sampled only at grant. Changing them mid-transaction is a protocol violation with undefined result, but it must not corrupt the FSM.

## Timing
- A request seen in IDLE at cycle 0 produces:
  - the LO beat in cycle 1;
  - the HI beat in cycle 2 (wide only);
  - CAP in cycle 2 (narrow) or cycle 3 (wide);
  - `done_o` in cycle 3 (narrow) or cycle 4 (wide).
- The requester must drop `req` in the `done_o` cycle. The arbiter already ignores it that cycle.
- Back-to-back: the other port can be granted in the `done_o` cycle, so its LO beat falls one cycle later. With both ports saturated, grants strictly alternate.
- All bus outputs, `done_o` and `rdata_o` are driven from flops; there are no combinational paths from inputs.
- Reset values: state IDLE; all `bus_*` outputs 0; `done_o=0`; `rdata_o=0`; pointer=0.
- Reset asserted mid-transaction aborts immediately. No further strobes and no `done_o` are produced. A wide write may be left half-done; that is accepted.

## Structure
- Shared package `reg_bus_pkg`:
  - state enum (IDLE, LO, HI, CAP);
  - `REG_ADDR_W=6`;
  - `REG_DATA_W=8`;
  - port indices `PORT_HOST=0` and `PORT_SEQ=1`.
- One sub-module, `rr_arb2`: two-way round-robin grant with a done-mask input and a pointer-advance input.
- The top level holds the FSM, the command latch and the result capture. Estimated 150–250 lines total.

## Test plan
- Narrow write: port 0 writes `addr=0x0A`, `wdata=0x0037`. Expect `bus_write` with addr 0x0A, data 0x37 in cycle 1; `done_o[0]` in cycle 3; no HI beat.
- Wide write: port 1 writes `addr=0x03`, `wdata=0xBEEF`. Expect 0x03←0xEF in cycle 1, 0x04←0xBE in cycle 2, `done_o[1]` in cycle 4.
- Wide read: the model returns 0x34 for 0x08 and 0x12 for 0x09. Expect `bus_read` in cycles 1 and 2, then `rdata_o=0x1234` with `done_o` in cycle 4. A narrow read of 0x0D (0xA5) gives `rdata_o=0x00A5`.
- Contention: both ports request wide writes continuously from reset. Grant order is 0,1,0,1. Port 0's two beats are never interleaved with port 1's. Each done-to-LO gap is 1 cycle.
- Wrap: a wide write at 0x3F gives HI beat addr 0x00.
- Reset: `rst_n` low during the HI beat. All outputs are 0 immediately, no `done_o` follows, and the next request proceeds normally from IDLE.
